serial_add_scheduler: RTL and testbench

Shares one bit-serial adder datapath between two requesters. Each requester hands over a pair of WIDTH-bit operands through a valid/ready handshake. The block arbitrates round-robin, streams the operands LSB-first through an internal one-bit full adder with a carry register, and assembles the parallel sum. It returns sum, carry-out and requester id on a single response channel with backpressure. It sits between parallel producers and the serial arithmetic datapath; the full adder is built from bitwise logic operations only (no `+`).

---
 rtl/serial_add_scheduler.sv | 156 +++++++++++++++
 tb/tb_serial_add_scheduler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_scheduler.sv
// serial_add_scheduler: two requesters share one bit-serial adder.
// Operands are accepted by round-robin arbitration, summed LSB-first through
// a one-bit full adder with a carry register, and the parallel sum is
// returned with carry-out and requester id on a backpressured response port.
module serial_add_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  // One-bit full adder from bitwise logic only; returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    logic s;
    logic co;
    s  = a ^ b ^ c;
    co = (a & b) | (c & (a ^ b));
    return {co, s};
  endfunction

  state_t           state_q, state_d;
  logic             ptr_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [WIDTH-1:0] sum_s;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             id_q;
  logic             cout_q;
  logic             rsp_valid_q;
  logic             busy_q;
  logic             grant0_s, grant1_s, accept_s;
  logic [1:0]       fa_s;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) state_d = ADD;
        else          state_d = IDLE;
      end
      ADD: begin
        if (cnt_q == LAST_BIT) state_d = DONE;
        else                   state_d = ADD;
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
        else           state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant/ready outputs: only in IDLE and out of reset; contention goes to
  // the requester that was not served last.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if ((state_q == IDLE) && rst) begin
      if (req0_valid && req1_valid) begin
        grant0_s = ptr_q;
        grant1_s = ~ptr_q;
      end else begin
        grant0_s = req0_valid;
        grant1_s = req1_valid;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign accept_s   = grant0_s | grant1_s;
  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;

  // Serial adder bit slice and the sum register shifted in from the MSB side.
  always_comb begin
    fa_s  = full_add(a_q[0], b_q[0], carry_q);
    sum_s = sum_q >> 1;
    sum_s[WIDTH-1] = fa_s[0];
  end

  // Datapath, arbitration pointer and registered response/busy outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= 1'b1;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      id_q        <= 1'b0;
      cout_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if (accept_s) begin
        a_q     <= grant1_s ? req1_a : req0_a;
        b_q     <= grant1_s ? req1_b : req0_b;
        id_q    <= grant1_s;
        ptr_q   <= grant1_s;
        carry_q <= 1'b0;
        cnt_q   <= '0;
      end else if (state_q == ADD) begin
        a_q     <= a_q >> 1;
        b_q     <= b_q >> 1;
        sum_q   <= sum_s;
        carry_q <= fa_s[1];
        cnt_q   <= cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) cout_q <= fa_s[1];
      end
      rsp_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign rsp_id    = id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_serial_add_scheduler.sv
// Directed bench for serial_add_scheduler (WIDTH=8 main instance plus a
// WIDTH=1 instance for the single-bit corner).
module tb_serial_add_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_a = 8'h00, req0_b = 8'h00, req1_a = 8'h00, req1_b = 8'h00;
  logic       rsp_valid, rsp_cout, rsp_id, busy;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_sum;

  logic       w1_req0_valid = 1'b0, w1_req1_valid = 1'b0;
  logic       w1_req0_ready, w1_req1_ready;
  logic       w1_req0_a = 1'b0, w1_req0_b = 1'b0, w1_req1_a = 1'b0, w1_req1_b = 1'b0;
  logic       w1_rsp_valid, w1_rsp_cout, w1_rsp_id, w1_busy, w1_rsp_sum;
  logic       w1_rsp_ready = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  serial_add_scheduler #(.WIDTH(8)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .rsp_id(rsp_id), .busy(busy)
  );

  serial_add_scheduler #(.WIDTH(1)) u_dut_w1 (
    .clk(clk), .rst(rst),
    .req0_valid(w1_req0_valid), .req0_ready(w1_req0_ready), .req0_a(w1_req0_a), .req0_b(w1_req0_b),
    .req1_valid(w1_req1_valid), .req1_ready(w1_req1_ready), .req1_a(w1_req1_a), .req1_b(w1_req1_b),
    .rsp_valid(w1_rsp_valid), .rsp_ready(w1_rsp_ready), .rsp_sum(w1_rsp_sum),
    .rsp_cout(w1_rsp_cout), .rsp_id(w1_rsp_id), .busy(w1_busy)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete operation on the WIDTH=8 instance with rsp_ready held high.
  task automatic do_op(input logic id, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] es, input logic ec);
    int n;
    if (id) begin
      req1_a = a; req1_b = b; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_valid = 1'b1;
    end
    #1;
    n = 0;
    while (((id ? req1_ready : req0_ready) !== 1'b1) && n < 20) begin
      tick();
      n++;
    end
    check("accept_wait", 64'(n < 20), 64'd1);
    check("ready_other", 64'(id ? req0_ready : req1_ready), 64'd0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("busy_add", 64'(busy), 64'd1);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("latency", 64'(n), 64'd8);
    check("sum", 64'(rsp_sum), 64'(es));
    check("cout", 64'(rsp_cout), 64'(ec));
    check("id", 64'(rsp_id), 64'(id));
    tick();
    check("rsp_one_cycle", 64'(rsp_valid), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    int hits;
    logic [8:0] gold;
    logic [7:0] ra, rb;
    logic rid;

    // Reset state, with a request pending to prove ready is held low.
    req0_valid = 1'b1;
    #12;
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sum", 64'(rsp_sum), 64'd0);
    check("rst_cout", 64'(rsp_cout), 64'd0);
    check("rst_id", 64'(rsp_id), 64'd0);
    check("rst_ready0", 64'(req0_ready), 64'd0);
    req0_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rst = 1'b1;
    #1;

    // Single op, then carry-out and carry isolation.
    do_op(1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0);
    do_op(1'b1, 8'hFF, 8'h01, 8'h00, 1'b1);
    do_op(1'b0, 8'h01, 8'h01, 8'h02, 1'b0);

    // Contention from reset: grants alternate 0,1,0,1.
    rst = 1'b0;
    tick();
    req0_a = 8'h10; req0_b = 8'h20; req1_a = 8'hF0; req1_b = 8'h20;
    req0_valid = 1'b1; req1_valid = 1'b1;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(req0_ready | req1_ready) && n < 20) begin
        tick();
        n++;
      end
      check("cont_wait", 64'(n < 20), 64'd1);
      check("cont_excl", 64'(req0_ready & req1_ready), 64'd0);
      check("cont_grant", 64'(req1_ready), 64'(k % 2));
      tick();
      check("cont_add_ready", 64'(req0_ready | req1_ready), 64'd0);
      n = 0;
      while (rsp_valid !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
      check("cont_latency", 64'(n), 64'd8);
      check("cont_id", 64'(rsp_id), 64'(k % 2));
      check("cont_sum", 64'(rsp_sum), (k % 2 == 1) ? 64'h10 : 64'h30);
      check("cont_cout", 64'(rsp_cout), (k % 2 == 1) ? 64'd1 : 64'd0);
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    // Backpressure: hold DONE for 5 cycles with a competing request pending.
    rsp_ready = 1'b0;
    req0_a = 8'h7F; req0_b = 8'h01; req0_valid = 1'b1;
    #1;
    check("bp_ready", 64'(req0_ready), 64'd1);
    tick();
    req0_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 64'(rsp_valid), 64'd1);
      check("bp_sum", 64'(rsp_sum), 64'h80);
      check("bp_cout", 64'(rsp_cout), 64'd0);
      check("bp_id", 64'(rsp_id), 64'd0);
      check("bp_readys", 64'(req0_ready | req1_ready), 64'd0);
      check("bp_busy", 64'(busy), 64'd1);
      tick();
    end
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    check("bp_release_valid", 64'(rsp_valid), 64'd0);
    check("bp_release_busy", 64'(busy), 64'd0);

    // Reset mid-ADD discards the operation.
    req1_a = 8'h33; req1_b = 8'h44; req1_valid = 1'b1;
    tick();
    req1_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b0;
    #1;
    check("mrst_valid", 64'(rsp_valid), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_sum", 64'(rsp_sum), 64'd0);
    check("mrst_id", 64'(rsp_id), 64'd0);
    tick();
    tick();
    rst = 1'b1;
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rsp_valid === 1'b1) hits++;
    end
    check("mrst_no_rsp", 64'(hits), 64'd0);
    do_op(1'b0, 8'h80, 8'h80, 8'h00, 1'b1);

    // Short random set against the golden a+b.
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rid = 1'($urandom_range(0, 1));
      gold = {1'b0, ra} + {1'b0, rb};
      do_op(rid, ra, rb, gold[7:0], gold[8]);
    end

    // WIDTH=1: one ADD cycle, cout = a & b.
    w1_rsp_ready = 1'b1;
    w1_req0_a = 1'b1; w1_req0_b = 1'b1; w1_req0_valid = 1'b1;
    #1;
    check("w1_ready0", 64'(w1_req0_ready), 64'd1);
    tick();
    w1_req0_valid = 1'b0;
    check("w1_add_valid", 64'(w1_rsp_valid), 64'd0);
    tick();
    check("w1_valid", 64'(w1_rsp_valid), 64'd1);
    check("w1_sum", 64'(w1_rsp_sum), 64'd0);
    check("w1_cout", 64'(w1_rsp_cout), 64'd1);
    tick();
    w1_req1_a = 1'b1; w1_req1_b = 1'b0; w1_req1_valid = 1'b1;
    #1;
    check("w1_ready1", 64'(w1_req1_ready), 64'd1);
    tick();
    w1_req1_valid = 1'b0;
    tick();
    check("w1_valid2", 64'(w1_rsp_valid), 64'd1);
    check("w1_sum2", 64'(w1_rsp_sum), 64'd1);
    check("w1_cout2", 64'(w1_rsp_cout), 64'd0);
    check("w1_id2", 64'(w1_rsp_id), 64'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
